// File: rtl/fa_by_ha.sv
// fa_by_ha: WIDTH-bit ripple-carry adder. Each cell is a full adder made from
// two half adders and an OR gate. The combinational sum/carry is also
// registered on clk. The register clears asynchronously while rst_n is low.
module fa_by_ha #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic             ip3,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
);

  // Ripple chain. cin_w[i] is the carry into cell i.
  // cin_w[WIDTH] is the carry out of the MSB cell.
  logic [WIDTH:0] cin_w;

  // Next-state values of the capture register. They are the live
  // combinational result.
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign cin_w[0] = ip3;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic s1, c1, c2;
    // HA1 adds the two operand bits.
    assign s1 = ip1[i] ^ ip2[i];
    assign c1 = ip1[i] & ip2[i];
    // HA2 adds the incoming carry to the partial sum from HA1.
    assign sum[i] = s1 ^ cin_w[i];
    assign c2     = s1 & cin_w[i];
    // The two half-adder carries can never both be 1, so OR gives the carry out.
    assign cin_w[i+1] = c1 | c2;
  end

  assign carry   = cin_w[WIDTH];
  assign sum_d   = sum;
  assign carry_d = carry;

  // Capture register: clears asynchronously and captures the combinational
  // result on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_fa_by_ha.sv
// Directed bench for fa_by_ha. It drives three instances (WIDTH = 1, 4, 8)
// from one shared clock and reset.
module tb_fa_by_ha;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a1, b1, c1_in;
  logic       s1, co1, s1_q, co1_q;
  logic [3:0] a4, b4, s4, s4_q;
  logic       c4_in, co4, co4_q;
  logic [7:0] a8, b8, s8, s8_q;
  logic       c8_in, co8, co8_q;

  int n_checks = 0;
  int n_errors = 0;

  fa_by_ha #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .ip1(a1), .ip2(b1), .ip3(c1_in),
    .sum(s1), .carry(co1), .sum_q(s1_q), .carry_q(co1_q)
  );
  fa_by_ha #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .ip1(a4), .ip2(b4), .ip3(c4_in),
    .sum(s4), .carry(co4), .sum_q(s4_q), .carry_q(co4_q)
  );
  fa_by_ha #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .ip1(a8), .ip2(b8), .ip3(c8_in),
    .sum(s8), .carry(co8), .sum_q(s8_q), .carry_q(co8_q)
  );

  // Clock: period 10 ns. Rising edges fall at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {carry,sum} for WIDTH=1, indexed by {ip1,ip2,ip3}.
  logic [1:0] w1_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  // WIDTH=4 vectors: a, b, cin, expected {carry,sum}.
  typedef struct { logic [3:0] a; logic [3:0] b; logic ci; logic [4:0] exp; } v4_t;
  v4_t v4_tab [6] = '{
    '{4'hF, 4'h0, 1'b1, 5'h10},
    '{4'h9, 4'h6, 1'b0, 5'h0F},
    '{4'h7, 4'h8, 1'b1, 5'h10},
    '{4'hA, 4'h5, 1'b0, 5'h0F},
    '{4'h3, 4'h4, 1'b1, 5'h08},
    '{4'hF, 4'hF, 1'b1, 5'h1F}
  };

  logic [8:0] exp_q [$];
  logic [8:0] exp8;

  initial begin
    a1 = 0; b1 = 0; c1_in = 0;
    a4 = 0; b4 = 0; c4_in = 0;
    a8 = 0; b8 = 0; c8_in = 0;

    // Reset state.
    #3;
    check("rst_w1_q", {14'd0, co1_q, s1_q}, 16'd0);
    check("rst_w4_q", {11'd0, co4_q, s4_q}, 16'd0);
    check("rst_w8_q", {7'd0, co8_q, s8_q}, 16'd0);

    // WIDTH=1 exhaustive while reset is held. The combinational path must
    // work during reset.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1_in = v[0];
      #2;
      check($sformatf("w1_comb_%0d", i), {14'd0, co1, s1}, {14'd0, w1_tab[i]});
    end
    // Rising edges have passed under reset. The registers must still be 0.
    check("rst_hold_w1_q", {14'd0, co1_q, s1_q}, 16'd0);

    // Release reset between edges. Registers hold 0 until the next rising edge.
    @(negedge clk);
    a1 = 1; b1 = 1; c1_in = 1;
    #1 rst_n = 1'b1;
    #1 check("rel_pre_edge_w1_q", {14'd0, co1_q, s1_q}, 16'd0);
    @(posedge clk);
    #1 check("rel_first_cap_w1_q", {14'd0, co1_q, s1_q}, 16'h3);

    // Async reset mid-cycle clears the registers at once. The combinational
    // outputs are unaffected.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_w1_q", {14'd0, co1_q, s1_q}, 16'd0);
    check("async_w1_comb", {14'd0, co1, s1}, 16'h3);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4 directed vectors: comb result, then registered copy after the edge.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a4 = v4_tab[i].a; b4 = v4_tab[i].b; c4_in = v4_tab[i].ci;
      #1 check($sformatf("w4_comb_%0d", i), {11'd0, co4, s4}, {11'd0, v4_tab[i].exp});
      @(posedge clk);
      #1 check($sformatf("w4_reg_%0d", i), {11'd0, co4_q, s4_q}, {11'd0, v4_tab[i].exp});
    end

    // WIDTH=8 random vectors checked against arithmetic. Each registered
    // output must equal the result of the previous cycle's inputs.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      c8_in = 1'($urandom_range(0, 1));
      exp8 = 9'(a8) + 9'(b8) + 9'(c8_in);
      exp_q.push_back(exp8);
      #1 check("w8_comb", {7'd0, co8, s8}, {7'd0, exp8});
      @(posedge clk);
      #1 check("w8_reg", {7'd0, co8_q, s8_q}, {7'd0, exp_q.pop_front()});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
